// File: rtl/vfd_pkg.sv
// Shared types, saturating arithmetic and the gamma curve for the VFD persistence engine.
package vfd_pkg;

  localparam int BRIGHT_W_DEF = 4;

  typedef logic [BRIGHT_W_DEF-1:0] bright_t;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    SWEEP = 2'd2
  } state_e;

  function automatic int unsigned sat_add(input int unsigned v,
                                          input int unsigned inc,
                                          input int unsigned max_v);
    int unsigned sum;
    sum = v + inc;
    return (sum > max_v) ? max_v : sum;
  endfunction

  function automatic int unsigned sat_sub(input int unsigned v,
                                          input int unsigned dec);
    return (v > dec) ? (v - dec) : 32'd0;
  endfunction

  // floor(15 * (x/15)^2.2) for the default 4-bit depth
  localparam bright_t GAMMA_LUT [16] = '{
    4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2,
    4'd3, 4'd4, 4'd6, 4'd7, 4'd9, 4'd10, 4'd12, 4'd15
  };

endpackage

// File: rtl/vfd_persist_ram.sv
// Simple dual-port table RAM: one write port, one registered read port that returns 0 out of range.
module vfd_persist_ram #(
  parameter int DEPTH = 160,
  parameter int AW    = 8,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // NOTE: the array has no reset; the engine's CLEAR state zeroes it, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                        rdata_q <= '0;
    else if ({1'b0, raddr_i} < DEPTH_W)  rdata_q <= mem_q[raddr_i];
    else                                 rdata_q <= '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vfd_persist.sv
// VFD phosphor-persistence engine: per-cell brightness rises when lit, decays otherwise.
// Optional: define VFD_PERSIST_GAMMA_EN to pass rd_data through the gamma LUT.
module vfd_persist
  import vfd_pkg::*;
#(
  parameter  int          NUM_GRIDS = 10,
  parameter  int          NUM_SEGS  = 16,
  parameter  int          BRIGHT_W  = 4,
  parameter  int unsigned ATTACK    = 4,
  parameter  int unsigned DECAY     = 1,
  localparam int          CELLS     = NUM_GRIDS * NUM_SEGS,
  localparam int          AW        = $clog2(CELLS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sample_ce,
  input  logic [NUM_GRIDS-1:0] grid,
  input  logic [NUM_SEGS-1:0]  seg,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun,
  input  logic [AW-1:0]        rd_addr,
  output logic [BRIGHT_W-1:0]  rd_data
);

  localparam int          GW    = (NUM_GRIDS > 1) ? $clog2(NUM_GRIDS) : 1;
  localparam int          SW    = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
  localparam int unsigned MAX_V = (32'd1 << BRIGHT_W) - 32'd1;
  localparam logic [AW-1:0] LAST = AW'(CELLS - 1);

  state_e               state_q, state_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic [GW-1:0]        g_q, g_d;
  logic [SW-1:0]        s_q, s_d;
  logic                 issue_q, issue_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [AW-1:0]        s2_addr_q, s2_addr_d;
  logic                 s2_lit_q, s2_lit_d;
  logic [NUM_GRIDS-1:0] grid_snap_q, grid_snap_d;
  logic [NUM_SEGS-1:0]  seg_snap_q, seg_snap_d;
  logic                 frame_done_q, frame_done_d;
  logic                 overrun_q, overrun_d;

  logic                 we;
  logic [AW-1:0]        waddr;
  logic [BRIGHT_W-1:0]  wdata;
  logic [BRIGHT_W-1:0]  new_val;
  logic [BRIGHT_W-1:0]  eng_rdata;
  logic [BRIGHT_W-1:0]  rend_rdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= CLEAR;
      ptr_q        <= '0;
      g_q          <= '0;
      s_q          <= '0;
      issue_q      <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_addr_q    <= '0;
      s2_lit_q     <= 1'b0;
      grid_snap_q  <= '0;
      seg_snap_q   <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      g_q          <= g_d;
      s_q          <= s_d;
      issue_q      <= issue_d;
      s2_valid_q   <= s2_valid_d;
      s2_addr_q    <= s2_addr_d;
      s2_lit_q     <= s2_lit_d;
      grid_snap_q  <= grid_snap_d;
      seg_snap_q   <= seg_snap_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    new_val = s2_lit_q ? BRIGHT_W'(sat_add(32'(eng_rdata), ATTACK, MAX_V))
                       : BRIGHT_W'(sat_sub(32'(eng_rdata), DECAY));
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    g_d          = g_q;
    s_d          = s_q;
    issue_d      = issue_q;
    s2_valid_d   = 1'b0;
    s2_addr_d    = s2_addr_q;
    s2_lit_d     = s2_lit_q;
    grid_snap_d  = grid_snap_q;
    seg_snap_d   = seg_snap_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    we           = 1'b0;
    waddr        = s2_addr_q;
    wdata        = new_val;

    case (state_q)
      CLEAR: begin
        we    = 1'b1;
        waddr = ptr_q;
        wdata = '0;
        if (ptr_q == LAST) begin
          ptr_d   = '0;
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end

      IDLE: begin
        if (sample_ce) begin
          grid_snap_d = grid;
          seg_snap_d  = seg;
          ptr_d       = '0;
          g_d         = '0;
          s_d         = '0;
          issue_d     = 1'b1;
          state_d     = SWEEP;
        end
      end

      SWEEP: begin
        // Includes the frame_done cycle: acceptance only happens once back in IDLE.
        if (sample_ce) overrun_d = 1'b1;

        if (issue_q) begin
          s2_valid_d = 1'b1;
          s2_addr_d  = ptr_q;
          s2_lit_d   = grid_snap_q[g_q] & seg_snap_q[s_q];
          if (s_q == SW'(NUM_SEGS - 1)) begin
            s_d = '0;
            g_d = g_q + GW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
          if (ptr_q == LAST) issue_d = 1'b0;
          else               ptr_d   = ptr_q + AW'(1);
        end

        if (s2_valid_q) begin
          we = 1'b1;
          if (s2_addr_q == LAST) frame_done_d = 1'b1;
        end

        if (frame_done_q) state_d = IDLE;
      end

      default: state_d = CLEAR;
    endcase
  end

  vfd_persist_ram #(.DEPTH(CELLS), .AW(AW), .DW(BRIGHT_W)) u_eng_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (ptr_q),
    .rdata_o (eng_rdata)
  );

  vfd_persist_ram #(.DEPTH(CELLS), .AW(AW), .DW(BRIGHT_W)) u_rend_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (rd_addr),
    .rdata_o (rend_rdata)
  );

  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

`ifdef VFD_PERSIST_GAMMA_EN
  // The LUT is constant logic behind the read register, so read latency stays one cycle.
  generate
    if (BRIGHT_W == BRIGHT_W_DEF) begin : g_gamma
      assign rd_data = GAMMA_LUT[rend_rdata];
    end else begin : g_raw
      assign rd_data = rend_rdata;
    end
  endgenerate
`else
  assign rd_data = rend_rdata;
`endif

endmodule

// File: tb/tb_vfd_persist.sv
// Randomised self-checking bench for vfd_persist against a per-cell array model.
module tb_vfd_persist;

  localparam int NUM_GRIDS = 10;
  localparam int NUM_SEGS  = 16;
  localparam int CELLS     = NUM_GRIDS * NUM_SEGS;
  localparam int AW        = 8;
  localparam int ATTACK    = 4;
  localparam int DECAY     = 1;
  localparam int MAXV      = 15;
  localparam int SWEEP_LAT = 162;

  logic                 clk;
  logic                 reset_n;
  logic                 sample_ce;
  logic [NUM_GRIDS-1:0] grid;
  logic [NUM_SEGS-1:0]  seg;
  logic                 busy;
  logic                 frame_done;
  logic                 overrun;
  logic [AW-1:0]        rd_addr;
  logic [3:0]           rd_data;

  int model [CELLS];
  int gtab  [16] = '{0, 0, 0, 0, 0, 1, 1, 2, 3, 4, 6, 7, 9, 10, 12, 15};
  int exp_up   [5] = '{4, 8, 12, 15, 15};
  int exp_down [3] = '{14, 13, 12};
  int n_checks = 0;
  int n_fail   = 0;

  vfd_persist dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_ce  (sample_ce),
    .grid       (grid),
    .seg        (seg),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_read(input int v);
`ifdef VFD_PERSIST_GAMMA_EN
    return gtab[v];
`else
    return v;
`endif
  endfunction

  function automatic void model_sweep(input logic [NUM_GRIDS-1:0] g, input logic [NUM_SEGS-1:0] s);
    for (int k = 0; k < CELLS; k++) begin
      if (g[k / NUM_SEGS] && s[k % NUM_SEGS])
        model[k] = (model[k] + ATTACK > MAXV) ? MAXV : model[k] + ATTACK;
      else
        model[k] = (model[k] < DECAY) ? 0 : model[k] - DECAY;
    end
  endfunction

  task automatic read_cell(input int addr, output logic [31:0] val);
    @(negedge clk);
    rd_addr = AW'(addr);
    @(posedge clk);
    @(negedge clk);
    val = 32'(rd_data);
  endtask

  task automatic verify_all(input string tag);
    logic [31:0] v;
    for (int k = 0; k < CELLS; k++) begin
      read_cell(k, v);
      check(tag, v, exp_read(model[k]));
    end
  endtask

  task automatic spot_check(input string tag, input int count);
    logic [31:0] v;
    int a;
    for (int i = 0; i < count; i++) begin
      a = $urandom_range(CELLS - 1, 0);
      read_cell(a, v);
      check(tag, v, exp_read(model[a]));
    end
  endtask

  // Waits out CLEAR; returns the number of busy cycles and whether frame_done was seen.
  task automatic wait_clear(output int cnt, output bit fd_seen);
    cnt = 0;
    fd_seen = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      if (frame_done === 1'b1) fd_seen = 1;
      cnt++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_sweep(input logic [NUM_GRIDS-1:0] g, input logic [NUM_SEGS-1:0] s,
                          input int drop_at, input bit drop_on_fd);
    int n;
    bit seen;
    @(negedge clk);
    check("idle_before_sweep", busy, 0);
    grid = g;
    seg = s;
    sample_ce = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 400) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      sample_ce = (n == drop_at);
      if (n == drop_at) begin
        grid = NUM_GRIDS'($urandom);
        seg  = NUM_SEGS'($urandom);
      end
      if (n == 1) check("busy_after_accept", busy, 1);
      if (frame_done === 1'b1) begin
        seen = 1;
        if (drop_on_fd) sample_ce = 1'b1;
      end
    end
    check("frame_done_seen", seen, 1);
    if (seen) begin
      check("sweep_latency", n, SWEEP_LAT);
      @(posedge clk);
      @(negedge clk);
      sample_ce = 1'b0;
      check("frame_done_one_cycle", frame_done, 0);
      check("idle_after_sweep", busy, 0);
      if (drop_on_fd) check("overrun_on_fd_cycle", overrun, 1);
    end
    sample_ce = 1'b0;
    model_sweep(g, s);
  endtask

  initial begin
    logic [31:0] v;
    int cnt;
    bit fd_seen;

    reset_n = 1'b0;
    sample_ce = 1'b0;
    grid = '0;
    seg = '0;
    rd_addr = '0;
    for (int k = 0; k < CELLS; k++) model[k] = 0;

    // Reset state and CLEAR duration
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 1);
    check("reset_frame_done", frame_done, 0);
    check("reset_overrun", overrun, 0);
    check("reset_rd_data", rd_data, 0);
    reset_n = 1'b1;
    wait_clear(cnt, fd_seen);
    check("clear_cycles", cnt, CELLS);
    check("clear_no_frame_done", fd_seen, 0);
    verify_all("cleared_cell");

    // Single lit cell
    do_sweep(10'h001, 16'h0001, -1, 0);
    read_cell(0, v);  check("cell0_first", v, exp_read(exp_up[0]));
    read_cell(1, v);  check("cell1_first", v, exp_read(0));
    read_cell(16, v); check("cell16_first", v, exp_read(0));

    // Attack saturation then decay
    for (int i = 1; i < 5; i++) begin
      do_sweep(10'h001, 16'h0001, -1, 0);
      read_cell(0, v);
      check("cell0_attack", v, exp_read(exp_up[i]));
    end
    for (int i = 0; i < 3; i++) begin
      do_sweep(10'h001, 16'h0000, -1, 0);
      read_cell(0, v);
      check("cell0_decay", v, exp_read(exp_down[i]));
    end
    repeat (4) do_sweep(10'h001, 16'h0000, -1, 0);
    read_cell(0, v);
    check("cell0_value8", v, exp_read(8));
    verify_all("table_after_decay");

    // Dropped sample mid-sweep
    check("overrun_clear_before_drop", overrun, 0);
    do_sweep(10'h0A5, 16'h3C3C, 20, 0);
    check("overrun_after_drop", overrun, 1);
    verify_all("first_snapshot_only");

    // Random multi-grid sweeps, one with a sample on the frame_done cycle
    for (int i = 0; i < 8; i++) begin
      do_sweep(NUM_GRIDS'($urandom), NUM_SEGS'($urandom), -1, (i == 3));
      spot_check("random_cell", 12);
    end
    verify_all("random_table");
    check("overrun_sticky", overrun, 1);

    // Out-of-range reads
    read_cell(CELLS, v);     check("oor_read_160", v, 0);
    read_cell(255, v);       check("oor_read_255", v, 0);

    // Reset mid-sweep
    @(negedge clk);
    grid = '1;
    seg = '1;
    sample_ce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample_ce = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    check("midreset_overrun_cleared", overrun, 0);
    wait_clear(cnt, fd_seen);
    check("midreset_clear_cycles", cnt, CELLS);
    check("midreset_no_frame_done", fd_seen, 0);
    check("midreset_overrun_after", overrun, 0);
    for (int k = 0; k < CELLS; k++) model[k] = 0;
    verify_all("midreset_cleared_cell");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
